clahe_cdf_engine: RTL
=====================

// Module: clahe_cdf_engine
// PURPOSE
//  Per-frame clip-limit + CDF engine. Sits between the 4-bank ping-pong tile RAM's CDF port and the
//  mapping stage. For each of 2**TILE_NUM_BITS tiles it reads 256 histogram bins, clips at clip_limit,
//  redistributes excess, accumulates CDF, normalises to 8 bit, writes the LUT back in place. Runs once per start.
// PARAMETERS
//  TILE_NUM_BITS  6     tile index width (64 tiles, processed 0..2**TILE_NUM_BITS-1)
//  TILE_PIXELS    4800  pixels per tile; localparam NORM_MULT = (255*65536 + TILE_PIXELS/2)/TILE_PIXELS
//  ACC_W          24    excess and CDF accumulator width
// PORTS
//  pclk          in   1   clock
//  rst           in   1   synchronous reset, active-high
//  start         in   1   1-cycle pulse: process all tiles; ignored while busy
//  clip_limit    in   16  clip threshold, sampled on accepted start; 0 = clipping disabled
//  busy          out  1   high from cycle after accepted start until done
//  done          out  1   1-cycle pulse after last write of last tile
//  cdf_tile_idx  out  TILE_NUM_BITS  tile being processed, stable for whole tile incl. drain
//  cdf_addr      out  8   bin address (read and write share it)
//  cdf_rd_en     out  1   read strobe; data valid on cdf_rd_data exactly 1 cycle later
//  cdf_rd_data   in   16  histogram bin
//  cdf_wr_en     out  1   write strobe
//  cdf_wr_data   out  8   normalised CDF value
// BEHAVIOUR
//  - Reset: all outputs 0, FSM IDLE, accumulators 0. Reset mid-operation aborts; no further strobes; tile restarts at 0.
//  - All outputs registered. FSM: IDLE -> READ -> CALC -> WRITE -> NEXT -> (READ | DONE) ; DONE -> IDLE.
//  - IDLE: start=1 latches clip (0 -> 0xFFFF), tile=0, -> READ.
//  - READ (257 cyc): cycles 0..255 drive cdf_addr=k, cdf_rd_en=1; cycles 1..256 capture cdf_rd_data into local
//    buf[k-1] (256x16) and add max(h-clip,0) to excess. Cycle 256 = drain, rd_en=0.
//  - CALC (1 cyc): redist = excess>>8; resid = excess[7:0]; cdf_acc=0.
//  - WRITE (256 cyc): bin k: c = min(buf[k],clip)+redist (+1 if residual feature and k<resid);
//    cdf_acc += c; out = min(255, (cdf_acc*NORM_MULT + 32768)>>16); registered as cdf_addr=k, cdf_wr_en=1,
//    cdf_wr_data=out. Product width ACC_W+17, saturation explicit; cdf_acc saturates at 2**ACC_W-1.
//  - NEXT (1 cyc): excess=0; tile==last -> DONE else tile+1 -> READ. Tile per-cycle cost = 515 cycles.
//  - DONE (1 cyc): done=1, busy falls same cycle as done; frame total 64*515+2 cycles start->done.
//  - h==clip gives zero excess. start during busy: no effect, clip not re-sampled.
//  - cdf_rd_en and cdf_wr_en never both high; ping-pong selection is outside this block.
// CONFIGURATION
//  CLAHE_CDF_RESIDUAL_EN defined: residual excess (excess mod 256) adds +1 to bins 0..resid-1, total count conserved.
//  Undefined: residual discarded; only redist added per bin. Cycle timing identical both ways.
// TESTING (bench overrides TILE_PIXELS=4096 -> NORM_MULT=4080)
//  1 all bins=16, clip_limit=0 -> bin0 out=1, bin127 out=128, bin255 out=255 on every tile.
//  2 bin100=4096 else 0, clip=64 -> excess 4032, redist 15; bin0 out=1, bin255 out=243 (255 with RESIDUAL_EN).
//  3 all bins=0xFFFF, clip=0 -> every cdf_wr_data=255 (saturation), no wrap.
//  4 start, second start at cycle 10 -> ignored; exactly one done, 64*515+2 cycles after first start; tile 0..63 once each.
//  5 rst=1 mid-WRITE of tile 5 -> next cycle cdf_wr_en=0, busy=0; new start processes tile 0 first.
//  6 protocol checker: cdf_tile_idx constant READ..NEXT; rd data captured exactly 1 cycle after rd_en; rd/wr never overlap.

Source files
------------

// File: rtl/clahe_cdf_engine.sv
// clahe_cdf_engine: per-frame clip-limit, excess redistribution and CDF-to-LUT engine over all tiles.
// Optional CLAHE_CDF_RESIDUAL_EN spreads the excess remainder as +1 over the lowest bins.
module clahe_cdf_engine #(
  parameter int TILE_NUM_BITS = 6,
  parameter int TILE_PIXELS = 4800,
  parameter int ACC_W = 24
) (
  input  logic                     pclk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [15:0]              clip_limit,
  output logic                     busy,
  output logic                     done,
  output logic [TILE_NUM_BITS-1:0] cdf_tile_idx,
  output logic [7:0]               cdf_addr,
  output logic                     cdf_rd_en,
  input  logic [15:0]              cdf_rd_data,
  output logic                     cdf_wr_en,
  output logic [7:0]               cdf_wr_data
);
  localparam int NORM_MULT = (255*65536 + TILE_PIXELS/2)/TILE_PIXELS;
  localparam int PW = ACC_W + 17;
  localparam logic [2:0] IDLE = 3'd0, READ = 3'd1, CALC = 3'd2, WRITE = 3'd3, NEXT = 3'd4, DONE = 3'd5;
  logic [2:0]       state;
  logic [8:0]       cnt;
  logic [15:0]      clip;
  logic [ACC_W-1:0] excess, cdf_acc, acc_nxt;
  logic [ACC_W-9:0] redist;
  logic [15:0]      hist [256];
  logic [15:0]      h_exc, bin, binc;
  logic             inc;
  logic [ACC_W:0]   acc_sum;
  logic [PW-1:0]    prod;
  logic [PW:0]      rnd;
  logic [7:0]       norm;
`ifdef CLAHE_CDF_RESIDUAL_EN
  logic [7:0]       resid;
  assign inc = cnt[7:0] < resid;
`else
  assign inc = 1'b0;
`endif
  always_comb begin
    h_exc = cdf_rd_data > clip ? cdf_rd_data - clip : 16'd0;
    bin = hist[cnt[7:0]];
    binc = bin > clip ? clip : bin;
    acc_sum = (ACC_W+1)'(cdf_acc) + (ACC_W+1)'(binc) + (ACC_W+1)'(redist) + (ACC_W+1)'(inc);
    acc_nxt = acc_sum[ACC_W] ? '1 : acc_sum[ACC_W-1:0];
    prod = PW'(acc_nxt) * PW'(NORM_MULT);
    rnd = (PW+1)'(prod) + (PW+1)'(32768);
    norm = |rnd[PW:24] ? 8'hFF : rnd[23:16];
  end
  // read data lags its strobe by one cycle, so READ count k lands bin k-1
  always_ff @(posedge pclk)
    if (state == READ && cnt != 9'd0) hist[cnt[7:0] - 8'd1] <= cdf_rd_data;
  always_ff @(posedge pclk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      clip <= '0;
      excess <= '0;
      cdf_acc <= '0;
      redist <= '0;
`ifdef CLAHE_CDF_RESIDUAL_EN
      resid <= '0;
`endif
      busy <= 1'b0;
      done <= 1'b0;
      cdf_tile_idx <= '0;
      cdf_addr <= '0;
      cdf_rd_en <= 1'b0;
      cdf_wr_en <= 1'b0;
      cdf_wr_data <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          clip <= clip_limit == 16'd0 ? 16'hFFFF : clip_limit;
          cdf_tile_idx <= '0;
          excess <= '0;
          cnt <= '0;
          busy <= 1'b1;
          cdf_addr <= '0;
          cdf_rd_en <= 1'b1;
          state <= READ;
        end
        READ: begin
          cdf_addr <= cnt[7:0] + 8'd1;
          cdf_rd_en <= cnt < 9'd255;
          if (cnt != 9'd0) excess <= excess + ACC_W'(h_exc);
          cnt <= cnt == 9'd256 ? 9'd0 : cnt + 9'd1;
          if (cnt == 9'd256) state <= CALC;
        end
        CALC: begin
          redist <= excess[ACC_W-1:8];
`ifdef CLAHE_CDF_RESIDUAL_EN
          resid <= excess[7:0];
`endif
          cdf_acc <= '0;
          cnt <= '0;
          state <= WRITE;
        end
        WRITE: begin
          cdf_acc <= acc_nxt;
          cdf_addr <= cnt[7:0];
          cdf_wr_en <= 1'b1;
          cdf_wr_data <= norm;
          cnt <= cnt + 9'd1;
          if (cnt == 9'd255) state <= NEXT;
        end
        NEXT: begin
          cdf_wr_en <= 1'b0;
          excess <= '0;
          cnt <= '0;
          if (&cdf_tile_idx) state <= DONE;
          else begin
            cdf_tile_idx <= cdf_tile_idx + 1'b1;
            cdf_addr <= '0;
            cdf_rd_en <= 1'b1;
            state <= READ;
          end
        end
        DONE: begin
          done <= 1'b1;
          busy <= 1'b0;
          cdf_tile_idx <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
